alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
// - Decodes a 32-bit RV32 instruction into the 3-bit ALU op code and the two ALU operands, and issues them to the ALU/EX stage.
// - Sits between register-file read (ID) and the ALU; it produces the data1/data2/ALUCtrl triple the ALU consumes.
// - Valid/ready on both sides; a 2-entry skid buffer gives 1-cycle latency and full throughput under back-pressure.
// PARAMETERS
// - CNT_W   8   width of the issued-op and illegal-op counters (wrap modulo 2^CNT_W)
// PORTS
// - clk_i         in   1   clock, all state on rising edge
// - rst_i         in   1   synchronous reset, active-high
// - flush_i       in   1   discard all buffered ops (branch redirect)
// - inst_valid_i  in   1   upstream op valid
// - inst_ready_o  out  1   stage can accept an op (registered)
// - inst_i        in   32  instruction word
// - rs1_data_i    in   32  rs1 register value
// - rs2_data_i    in   32  rs2 register value
// - ex_valid_o    out  1   issued op valid
// - ex_ready_i    in   1   ALU/EX stage accepts the op
// - ex_data1_o    out  32  ALU operand 1
// - ex_data2_o    out  32  ALU operand 2
// - ex_ctrl_o     out  3   ALU op code
// - ex_rd_o       out  5   destination register
// - ex_we_o       out  1   register write enable for this op
// - illegal_o     out  1   1-cycle pulse: accepted op was undecodable and dropped
// - issued_cnt_o  out  CNT_W  ops handed to EX
// - illegal_cnt_o out  CNT_W  ops dropped as illegal
// BEHAVIOUR
// - Op codes: AND=000 XOR=001 SLL=010 ADD=011 SUB=100 MUL=101 ADDI=110 SRAI=111.
// - Decode (opcode / funct3 / funct7):
//   0110011: 111/0000000 AND; 100/0000000 XOR; 001/0000000 SLL; 000/0000000 ADD; 000/0100000 SUB; 000/0000001 MUL
//   0010011: 000 ADDI (imm = sext inst[31:20]); 101 with funct7 0100000 SRAI (data2 = zext inst[24:20])
//   0000011 load: ADDI, imm = sext inst[31:20], we=1; 0100011 store: ADDI, imm = sext {inst[31:25],inst[11:7]}, we=0
//   1100011 beq (funct3 000): SUB, data2 = rs2, we=0
//   anything else: illegal
// - data1 = rs1_data_i always; data2 = rs2_data_i for R-type/beq, immediate otherwise; rd = inst[11:7]; we=1 for R/I/load.
// - Accept = inst_valid_i & inst_ready_o. Legal accepted op enters the buffer; illegal accepted op is dropped, illegal_o=1 next cycle, illegal_cnt_o+1.
// - Buffer FSM (OUT = output register, SKID = overflow register):
//   EMPTY: accept -> ONE (op in OUT next cycle; latency 1 cycle)
//   ONE:   accept & ex_ready_i -> ONE (new op to OUT); accept & !ex_ready_i -> FULL (new op to SKID);
//          !accept & ex_ready_i -> EMPTY; else hold
//   FULL:  ex_ready_i -> ONE (SKID moves to OUT); else hold. No accept possible in FULL.
// - inst_ready_o = (state != FULL), registered; ex_valid_o = (state != EMPTY).
// - ex_* outputs are stable while ex_valid_o & !ex_ready_i. Order is strictly preserved.
// - issued_cnt_o +1 on every ex_valid_o & ex_ready_i; both counters wrap at 2^CNT_W.
// - flush_i: next state EMPTY, OUT/SKID invalidated; any handshake in the flush cycle (in or out) is consumed and discarded, counters not incremented by it, illegal_o not raised.
// - Reset (rst_i=1, priority over flush_i): state EMPTY, ex_valid_o=0, inst_ready_o=1, ex_data1_o/ex_data2_o=0, ex_ctrl_o=0, ex_rd_o=0, ex_we_o=0, illegal_o=0, both counters 0. Reset mid-transfer drops buffered ops.
// TESTING
// - add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, ex_ready_i=1 -> next cycle ex_valid_o=1, ctrl=011, data1=5, data2=7, rd=3, we=1.
// - srai x5,x6,4 (0x40435293), rs1=0x80000000 -> ctrl=111, data2=4, rd=5; sw x2,-4(x1) (0xFE20AE23) -> ctrl=110, data2=0xFFFFFFFC, we=0.
// - Stream 4 back-to-back ops, ex_ready_i low 3 cycles -> FULL after 2 accepts, inst_ready_o=0, outputs held; on release all 4 issued in order, issued_cnt_o=4.
// - Undecodable 0x0000007F -> no ex_valid_o, illegal_o pulse 1 cycle, illegal_cnt_o=1; following legal op issues normally.
// - FULL state, flush_i=1 with ex_ready_i=1 -> next cycle ex_valid_o=0, inst_ready_o=1, issued_cnt_o unchanged.
// - 256 issued ops with CNT_W=8 -> issued_cnt_o wraps to 0; rst_i asserted in FULL -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// Decodes an RV32 instruction into a 3-bit ALU op code plus two operands and
// issues the result to the ALU/EX stage through a 2-entry skid buffer
// (OUT register feeding EX, SKID register catching one op of back-pressure).
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_i               discard every buffered op and any handshake this cycle
//   inst_valid_i/_ready_o upstream handshake (ready is registered)
//   inst_i, rs1_data_i, rs2_data_i  instruction and register-file operands
//   ex_valid_o/ex_ready_i downstream handshake
//   ex_data1_o, ex_data2_o, ex_ctrl_o, ex_rd_o, ex_we_o  issued op
//   illegal_o             1-cycle pulse when an accepted op was undecodable
//   issued_cnt_o, illegal_cnt_o  wrapping event counters
// -----------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             inst_valid_i,
    output logic             inst_ready_o,
    input  logic [31:0]      inst_i,
    input  logic [31:0]      rs1_data_i,
    input  logic [31:0]      rs2_data_i,
    output logic             ex_valid_o,
    input  logic             ex_ready_i,
    output logic [31:0]      ex_data1_o,
    output logic [31:0]      ex_data2_o,
    output logic [2:0]       ex_ctrl_o,
    output logic [4:0]       ex_rd_o,
    output logic             ex_we_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] issued_cnt_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_SLL  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_ADDI = 3'b110;
    localparam logic [2:0] OP_SRAI = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] data1;
        logic [31:0] data2;
        logic [2:0]  ctrl;
        logic [4:0]  rd;
        logic        we;
    } op_t;

    state_e     state_q, state_d;
    logic       ready_q;
    op_t        out_q, skid_q, dec_s;
    logic       dec_legal_s;
    logic       illegal_q;
    logic [CNT_W-1:0] issued_q, illegal_cnt_q;

    logic       accept_s, load_s, pop_s, drop_s;
    logic       out_new_s, out_skid_s, skid_new_s;

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;
    logic       unused_rs_idx_s;

    assign opcode_s = inst_i[6:0];
    assign funct3_s = inst_i[14:12];
    assign funct7_s = inst_i[31:25];
    // Register indices arrive already resolved as rs1/rs2 data.
    assign unused_rs_idx_s = ^inst_i[19:15];

    // Instruction decode: op code, second operand, write enable, legality.
    always_comb begin
        dec_s.data1 = rs1_data_i;
        dec_s.data2 = rs2_data_i;
        dec_s.ctrl  = OP_AND;
        dec_s.rd    = inst_i[11:7];
        dec_s.we    = 1'b0;
        dec_legal_s = 1'b0;
        case (opcode_s)
            7'b0110011: begin
                dec_s.we    = 1'b1;
                dec_legal_s = 1'b1;
                if (funct7_s == 7'b0000000) begin
                    case (funct3_s)
                        3'b111:  dec_s.ctrl = OP_AND;
                        3'b100:  dec_s.ctrl = OP_XOR;
                        3'b001:  dec_s.ctrl = OP_SLL;
                        3'b000:  dec_s.ctrl = OP_ADD;
                        default: dec_legal_s = 1'b0;
                    endcase
                end else if ((funct7_s == 7'b0100000) && (funct3_s == 3'b000)) begin
                    dec_s.ctrl = OP_SUB;
                end else if ((funct7_s == 7'b0000001) && (funct3_s == 3'b000)) begin
                    dec_s.ctrl = OP_MUL;
                end else begin
                    dec_legal_s = 1'b0;
                end
            end
            7'b0010011: begin
                dec_s.we = 1'b1;
                if (funct3_s == 3'b000) begin
                    dec_s.ctrl  = OP_ADDI;
                    dec_s.data2 = {{20{inst_i[31]}}, inst_i[31:20]};
                    dec_legal_s = 1'b1;
                end else if ((funct3_s == 3'b101) && (funct7_s == 7'b0100000)) begin
                    dec_s.ctrl  = OP_SRAI;
                    dec_s.data2 = {27'd0, inst_i[24:20]};
                    dec_legal_s = 1'b1;
                end else begin
                    dec_legal_s = 1'b0;
                end
            end
            7'b0000011: begin
                // Loads use the ALU for address generation.
                dec_s.ctrl  = OP_ADDI;
                dec_s.data2 = {{20{inst_i[31]}}, inst_i[31:20]};
                dec_s.we    = 1'b1;
                dec_legal_s = 1'b1;
            end
            7'b0100011: begin
                dec_s.ctrl  = OP_ADDI;
                dec_s.data2 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
                dec_legal_s = 1'b1;
            end
            7'b1100011: begin
                // beq compares by subtraction; other branch types are not handled here.
                if (funct3_s == 3'b000) begin
                    dec_s.ctrl  = OP_SUB;
                    dec_legal_s = 1'b1;
                end else begin
                    dec_legal_s = 1'b0;
                end
            end
            default: dec_legal_s = 1'b0;
        endcase
    end

    // Handshake qualifiers; a flush swallows both sides' handshakes.
    assign accept_s = inst_valid_i & ready_q;
    assign pop_s    = ex_valid_o & ex_ready_i & ~flush_i;
    assign load_s   = accept_s & dec_legal_s & ~flush_i;
    assign drop_s   = accept_s & ~dec_legal_s & ~flush_i;

    // FSM state register; ready is derived from the next state so it is a flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_FULL);
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: state_d = load_s ? ST_ONE : ST_EMPTY;
                ST_ONE: begin
                    if (load_s && !pop_s) begin
                        state_d = ST_FULL;
                    end else if (!load_s && pop_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL:  state_d = pop_s ? ST_ONE : ST_FULL;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // FSM outputs: downstream valid and buffer register load selects.
    always_comb begin
        ex_valid_o = (state_q != ST_EMPTY);
        out_new_s  = 1'b0;
        out_skid_s = 1'b0;
        skid_new_s = 1'b0;
        case (state_q)
            ST_EMPTY: out_new_s = load_s;
            ST_ONE: begin
                out_new_s  = load_s & pop_s;
                skid_new_s = load_s & ~pop_s;
            end
            ST_FULL:  out_skid_s = pop_s;
            default:  out_new_s = 1'b0;
        endcase
    end

    // OUT/SKID payload registers, illegal pulse and event counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q         <= '0;
            skid_q        <= '0;
            illegal_q     <= 1'b0;
            issued_q      <= '0;
            illegal_cnt_q <= '0;
        end else begin
            if (out_new_s) begin
                out_q <= dec_s;
            end else if (out_skid_s) begin
                out_q <= skid_q;
            end else begin
                out_q <= out_q;
            end
            if (skid_new_s) begin
                skid_q <= dec_s;
            end else begin
                skid_q <= skid_q;
            end
            illegal_q <= drop_s;
            if (pop_s) begin
                issued_q <= issued_q + CNT_W'(1);
            end else begin
                issued_q <= issued_q;
            end
            if (drop_s) begin
                illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
            end else begin
                illegal_cnt_q <= illegal_cnt_q;
            end
        end
    end

    assign inst_ready_o  = ready_q;
    assign ex_data1_o    = out_q.data1;
    assign ex_data2_o    = out_q.data2;
    assign ex_ctrl_o     = out_q.ctrl;
    assign ex_rd_o       = out_q.rd;
    assign ex_we_o       = out_q.we;
    assign illegal_o     = illegal_q;
    assign issued_cnt_o  = issued_q;
    assign illegal_cnt_o = illegal_cnt_q;

endmodule
